alu_operand_sequencer: RTL and testbench
========================================

Name: alu_operand_sequencer

Overview:
- Multicycle control FSM that drives the ALU operand selects and ALU operation for fetch, decode and execute.
- Drives ALUSrcA (0=PC, 1=reg A).
- Drives ALUSrcB[1:0] (00=reg B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2).
- Drives the 3-bit ALU op, plus the register-file, IR and PC write enables around them.
- Sits between top-level control and the ALU-operand muxes. It covers the R-type add/sub/and, addi, beq and bne subset.

Parameters:
- MEM_WAIT, 1, extra cycles the instruction memory needs before IR data is valid (0..3).
- CNT_W, 2, width of the wait counter; must satisfy 2^CNT_W > MEM_WAIT.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin one instruction; sampled only in IDLE.
- opcode  in  6  IR[31:26]; valid from DECODE onward.
- funct  in  6  IR[5:0]; valid from DECODE onward.
- zero  in  1  ALU zero flag, same-cycle combinational.
- alu_src_a  out  1  ALU A-operand select.
- alu_src_b  out  2  ALU B-operand select.
- alu_op  out  3  ALU operation (001 add, 010 sub, 011 and).
- ir_write  out  1  IR load enable.
- mem_read  out  1  instruction memory read.
- pc_write  out  1  PC load enable.
- pc_source  out  1  0=ALU result, 1=ALUOut register.
- aluout_write  out  1  ALUOut register load.
- reg_write  out  1  register-file write enable.
- reg_dst  out  1  0=rt, 1=rd.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on instruction completion.
- err  out  1  one-cycle pulse on unsupported opcode/funct.

Behaviour:
- State register updates on the rising edge of clk.
- Async reset forces IDLE, clears the wait counter and clears the class register. All outputs are 0 while reset is high and in IDLE.
- Outputs are decoded from the state, the latched class and zero. Unlisted outputs are 0 in every state.
- Reset asserted mid-instruction: immediate return to IDLE with no write enables asserted. No partial writes occur after reset deasserts.
- IDLE: if start=1, go to FETCH and clear the counter.
- FETCH (MEM_WAIT+1 cycles):
  - mem_read=1, alu_src_a=0, alu_src_b=01, alu_op=001.
  - Counter increments each cycle.
  - On the last cycle (counter==MEM_WAIT): ir_write=1, pc_write=1, pc_source=0, then go to DECODE.
  - MEM_WAIT=0 gives a single FETCH cycle.
- DECODE (1 cycle):
  - alu_src_a=0, alu_src_b=11, alu_op=001, aluout_write=1 (branch target).
  - Latch class from opcode/funct.
  - opcode 000000 with funct 100000/100010/100100 → EXEC_R.
  - 001000 → EXEC_I.
  - 000100/000101 → BRANCH.
  - Anything else → ERROR.
- EXEC_R:
  - alu_src_a=1, alu_src_b=00, aluout_write=1 → WB.
  - alu_op: 001 for funct 100000, 010 for 100010, 011 for 100100.
- EXEC_I: alu_src_a=1, alu_src_b=10, alu_op=001, aluout_write=1 → WB.
- WB: reg_write=1; reg_dst=1 for R class, 0 for addi → DONE.
- BRANCH:
  - alu_src_a=1, alu_src_b=00, alu_op=010, pc_source=1 → DONE.
  - pc_write = zero for beq; pc_write = ~zero for bne (same cycle).
- DONE: done=1 for one cycle → IDLE. A start held high re-fetches on the cycle after returning to IDLE.
- ERROR: err=1 for one cycle → IDLE.
- No write enable is asserted in ERROR.
- pc_write is asserted at most once per FETCH and at most once per BRANCH.
- Latency from IDLE with start=1 until the done pulse:
  - R/addi: MEM_WAIT+5 cycles.
  - branch: MEM_WAIT+4 cycles.
- busy is 1 from the FETCH entry through DONE/ERROR inclusive.

Decomposition:
- Package alu_seq_pkg holds:
  - state enum (IDLE, FETCH, DECODE, EXEC_R, EXEC_I, WB, BRANCH, DONE, ERROR);
  - ALU op constants ALU_ADD=001, ALU_SUB=010, ALU_AND=011;
  - SRCB_REG/SRCB_FOUR/SRCB_IMM/SRCB_IMM_SH constants;
  - opcode and funct constants;
  - class enum (CLS_R, CLS_I, CLS_BR).
- One sub-module: alu_seq_decode, a combinational map from opcode/funct to class, R-type alu_op and a valid flag. FSM and outputs stay in the top.

Test Plan:
- Reset, then start=1 with opcode=000000, funct=100010, MEM_WAIT=1 → alu_src_b sequence 01,01,11,00 with alu_op=010 in EXEC_R; reg_write=1 and reg_dst=1 in WB; done exactly 6 cycles after start is sampled.
- addi (opcode 001000) → EXEC_I drives alu_src_a=1, alu_src_b=10, alu_op=001; WB has reg_dst=0; err stays 0.
- beq with zero=1 in BRANCH → pc_write=1, pc_source=1. Repeat with zero=0 → pc_write=0. bne with zero=0 → pc_write=1.
- opcode 100011 → err pulses one cycle after DECODE; reg_write and pc_write stay 0 after FETCH; next start restarts normally.
- Reset asserted during EXEC_R → all outputs 0 immediately (async) and state IDLE. After release, no reg_write occurs without a new start.
- MEM_WAIT=0 build, start held high continuously → back-to-back instructions; FETCH lasts 1 cycle; one IDLE cycle separates done and the next mem_read.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared types and constants for the ALU operand sequencer
package alu_seq_pkg;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        EXEC_R = 4'd3,
        EXEC_I = 4'd4,
        WB     = 4'd5,
        BRANCH = 4'd6,
        DONE   = 4'd7,
        ERROR  = 4'd8
    } state_t;

    typedef enum logic [1:0] {
        CLS_R  = 2'd0,
        CLS_I  = 2'd1,
        CLS_BR = 2'd2
    } cls_t;

    localparam logic [2:0] ALU_ADD = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_AND = 3'b011;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;

    // Everything EXEC/WB/BRANCH need, captured once in DECODE.
    typedef struct packed {
        cls_t       cls;
        logic [2:0] r_op;
        logic       is_bne;
    } insn_t;

endpackage

// File: rtl/alu_seq_decode.sv
// rtl/alu_seq_decode.sv - combinational opcode/funct to instruction class map
module alu_seq_decode
    import alu_seq_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output cls_t       cls,
    output logic [2:0] r_op,
    output logic       is_bne,
    output logic       valid
);

    always_comb begin
        cls    = CLS_R;
        r_op   = ALU_ADD;
        is_bne = 1'b0;
        valid  = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                cls = CLS_R;
                case (funct)
                    FN_ADD: begin r_op = ALU_ADD; valid = 1'b1; end
                    FN_SUB: begin r_op = ALU_SUB; valid = 1'b1; end
                    FN_AND: begin r_op = ALU_AND; valid = 1'b1; end
                    default: valid = 1'b0;
                endcase
            end
            OP_ADDI: begin
                cls   = CLS_I;
                valid = 1'b1;
            end
            OP_BEQ: begin
                cls   = CLS_BR;
                valid = 1'b1;
            end
            OP_BNE: begin
                cls    = CLS_BR;
                is_bne = 1'b1;
                valid  = 1'b1;
            end
            default: valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_operand_sequencer.sv
// rtl/alu_operand_sequencer.sv - multicycle FSM driving ALU operand selects, op and write enables
module alu_operand_sequencer
    import alu_seq_pkg::*;
#(
    parameter int MEM_WAIT = 1,
    parameter int CNT_W    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_op,
    output logic       ir_write,
    output logic       mem_read,
    output logic       pc_write,
    output logic       pc_source,
    output logic       aluout_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       busy,
    output logic       done,
    output logic       err
);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    insn_t            insn;

    cls_t       dec_cls;
    logic [2:0] dec_r_op;
    logic       dec_is_bne;
    logic       dec_valid;
    logic       fetch_last;

    alu_seq_decode u_decode (
        .opcode (opcode),
        .funct  (funct),
        .cls    (dec_cls),
        .r_op   (dec_r_op),
        .is_bne (dec_is_bne),
        .valid  (dec_valid)
    );

    assign fetch_last = (cnt == CNT_W'(MEM_WAIT));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            insn  <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE)
                cnt <= '0;
            else if (state == FETCH)
                cnt <= cnt + 1'b1;
            if (state == DECODE) begin
                insn.cls    <= dec_cls;
                insn.r_op   <= dec_r_op;
                insn.is_bne <= dec_is_bne;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = FETCH;
            FETCH:   if (fetch_last) state_nxt = DECODE;
            DECODE: begin
                if (!dec_valid)
                    state_nxt = ERROR;
                else begin
                    case (dec_cls)
                        CLS_R:   state_nxt = EXEC_R;
                        CLS_I:   state_nxt = EXEC_I;
                        CLS_BR:  state_nxt = BRANCH;
                        default: state_nxt = ERROR;
                    endcase
                end
            end
            EXEC_R:  state_nxt = WB;
            EXEC_I:  state_nxt = WB;
            WB:      state_nxt = DONE;
            BRANCH:  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            ERROR:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        alu_src_a    = 1'b0;
        alu_src_b    = SRCB_REG;
        alu_op       = 3'b000;
        ir_write     = 1'b0;
        mem_read     = 1'b0;
        pc_write     = 1'b0;
        pc_source    = 1'b0;
        aluout_write = 1'b0;
        reg_write    = 1'b0;
        reg_dst      = 1'b0;
        busy         = (state != IDLE);
        done         = 1'b0;
        err          = 1'b0;
        case (state)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_FOUR;
                alu_op    = ALU_ADD;
                ir_write  = fetch_last;
                pc_write  = fetch_last;
            end
            DECODE: begin
                // Speculative branch target into ALUOut before the class is known.
                alu_src_b    = SRCB_IMM_SH;
                alu_op       = ALU_ADD;
                aluout_write = 1'b1;
            end
            EXEC_R: begin
                alu_src_a    = 1'b1;
                alu_src_b    = SRCB_REG;
                alu_op       = insn.r_op;
                aluout_write = 1'b1;
            end
            EXEC_I: begin
                alu_src_a    = 1'b1;
                alu_src_b    = SRCB_IMM;
                alu_op       = ALU_ADD;
                aluout_write = 1'b1;
            end
            WB: begin
                reg_write = 1'b1;
                reg_dst   = (insn.cls == CLS_R);
            end
            BRANCH: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_REG;
                alu_op    = ALU_SUB;
                pc_source = 1'b1;
                pc_write  = insn.is_bne ? ~zero : zero;
            end
            DONE:    done = 1'b1;
            ERROR:   err  = 1'b1;
            default: busy = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// tb/tb_alu_operand_sequencer.sv - randomized self-checking bench against a per-instruction trace model
module tb_alu_operand_sequencer;

    typedef struct packed {
        logic       a;
        logic [1:0] b;
        logic [2:0] op;
        logic       irw;
        logic       mr;
        logic       pcw;
        logic       pcs;
        logic       aow;
        logic       rw;
        logic       rd;
        logic       busy;
        logic       done;
        logic       err;
    } out_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start1 = 1'b0;
    logic       start0 = 1'b0;
    logic [5:0] opcode = '0;
    logic [5:0] funct = '0;
    logic       zero = 1'b0;

    logic       a1, irw1, mr1, pcw1, pcs1, aow1, rw1, rd1, busy1, done1, err1;
    logic [1:0] b1;
    logic [2:0] op1;
    logic       a0, irw0, mr0, pcw0, pcs0, aow0, rw0, rd0, busy0, done0, err0;
    logic [1:0] b0;
    logic [2:0] op0;

    out_t obs1, obs0;
    assign obs1 = {a1, b1, op1, irw1, mr1, pcw1, pcs1, aow1, rw1, rd1, busy1, done1, err1};
    assign obs0 = {a0, b0, op0, irw0, mr0, pcw0, pcs0, aow0, rw0, rd0, busy0, done0, err0};

    always #5 clk = ~clk;

    alu_operand_sequencer #(.MEM_WAIT(1), .CNT_W(2)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .opcode(opcode), .funct(funct), .zero(zero),
        .alu_src_a(a1), .alu_src_b(b1), .alu_op(op1), .ir_write(irw1), .mem_read(mr1),
        .pc_write(pcw1), .pc_source(pcs1), .aluout_write(aow1), .reg_write(rw1), .reg_dst(rd1),
        .busy(busy1), .done(done1), .err(err1)
    );

    alu_operand_sequencer #(.MEM_WAIT(0), .CNT_W(2)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .opcode(opcode), .funct(funct), .zero(zero),
        .alu_src_a(a0), .alu_src_b(b0), .alu_op(op0), .ir_write(irw0), .mem_read(mr0),
        .pc_write(pcw0), .pc_source(pcs0), .aluout_write(aow0), .reg_write(rw0), .reg_dst(rd0),
        .busy(busy0), .done(done0), .err(err0)
    );

    int   n_tests = 0;
    int   n_fail  = 0;
    out_t exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected per-cycle outputs for one instruction, first FETCH cycle through DONE/ERROR.
    function automatic void build(input int mw, input logic [5:0] op, input logic [5:0] fn, input logic z);
        out_t o;
        bit   is_r, is_i, is_br;
        exp_q.delete();
        for (int i = 0; i <= mw; i++) begin
            o = '0; o.busy = 1; o.mr = 1; o.b = 2'b01; o.op = 3'b001;
            if (i == mw) begin o.irw = 1; o.pcw = 1; end
            exp_q.push_back(o);
        end
        o = '0; o.busy = 1; o.b = 2'b11; o.op = 3'b001; o.aow = 1;
        exp_q.push_back(o);
        is_r  = (op == 6'd0) && (fn == 6'd32 || fn == 6'd34 || fn == 6'd36);
        is_i  = (op == 6'd8);
        is_br = (op == 6'd4) || (op == 6'd5);
        if (is_r || is_i) begin
            o = '0; o.busy = 1; o.a = 1; o.aow = 1;
            o.b  = is_r ? 2'b00 : 2'b10;
            o.op = !is_r ? 3'b001 : (fn == 6'd32) ? 3'b001 : (fn == 6'd34) ? 3'b010 : 3'b011;
            exp_q.push_back(o);
            o = '0; o.busy = 1; o.rw = 1; o.rd = is_r;
            exp_q.push_back(o);
        end else if (is_br) begin
            o = '0; o.busy = 1; o.a = 1; o.b = 2'b00; o.op = 3'b010; o.pcs = 1;
            o.pcw = (op == 6'd4) ? z : !z;
            exp_q.push_back(o);
        end else begin
            o = '0; o.busy = 1; o.err = 1;
            exp_q.push_back(o);
            return;
        end
        o = '0; o.busy = 1; o.done = 1;
        exp_q.push_back(o);
    endfunction

    // Called at a negedge with dut1 idle; ends at a negedge with dut1 idle again.
    task automatic run1(input string tag, input logic [5:0] op, input logic [5:0] fn, input logic z);
        opcode = op; funct = fn; zero = z;
        build(1, op, fn, z);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        for (int k = 0; k < exp_q.size(); k++) begin
            check($sformatf("%s_c%0d", tag, k), 32'(obs1), 32'(exp_q[k]));
            @(negedge clk);
        end
        check($sformatf("%s_idle", tag), 32'(obs1), 32'd0);
    endtask

    initial begin
        logic [5:0] ops[8];
        logic [5:0] fns[4];
        ops = '{6'd0, 6'd0, 6'd0, 6'd8, 6'd4, 6'd5, 6'b100011, 6'd0};
        fns = '{6'd32, 6'd34, 6'd36, 6'd0};

        #1;
        check("rst_outs1", 32'(obs1), 32'd0);
        check("rst_outs0", 32'(obs0), 32'd0);
        start1 = 1'b1;
        @(negedge clk);
        check("rst_held_start", 32'(obs1), 32'd0);
        start1 = 1'b0;
        reset  = 1'b0;
        @(negedge clk);
        check("idle_after_rst", 32'(obs1), 32'd0);

        run1("sub", 6'd0, 6'b100010, 1'b0);
        run1("addi", 6'b001000, 6'd0, 1'b0);
        run1("beq_z1", 6'b000100, 6'd0, 1'b1);
        run1("beq_z0", 6'b000100, 6'd0, 1'b0);
        run1("bne_z0", 6'b000101, 6'd0, 1'b0);
        run1("bne_z1", 6'b000101, 6'd0, 1'b1);
        run1("lw_err", 6'b100011, 6'd0, 1'b0);
        run1("after_err", 6'd0, 6'b100100, 1'b0);
        run1("badfn", 6'd0, 6'b101010, 1'b1);

        // Reset asynchronously while in EXEC_R.
        opcode = 6'd0; funct = 6'b100000; zero = 1'b0;
        build(1, 6'd0, 6'b100000, 1'b0);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("pre_rst_c%0d", k), 32'(obs1), 32'(exp_q[k]));
            @(negedge clk);
        end
        check("exec_r_before_rst", 32'(obs1), 32'(exp_q[3]));
        #2 reset = 1'b1;
        #1 check("async_rst_outs", 32'(obs1), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check($sformatf("post_rst_quiet%0d", k), 32'(obs1), 32'd0);
        end
        run1("post_rst_add", 6'd0, 6'b100000, 1'b1);

        // Back-to-back with MEM_WAIT=0 and start held high.
        opcode = 6'd0; funct = 6'b100010; zero = 1'b0;
        build(0, 6'd0, 6'b100010, 1'b0);
        start0 = 1'b1;
        @(negedge clk);
        for (int n = 0; n < 3; n++) begin
            for (int k = 0; k < exp_q.size(); k++) begin
                check($sformatf("b2b%0d_c%0d", n, k), 32'(obs0), 32'(exp_q[k]));
                @(negedge clk);
            end
            check($sformatf("b2b%0d_gap", n), 32'(obs0), 32'd0);
            if (n == 2) start0 = 1'b0;
            @(negedge clk);
        end
        check("b2b_stop", 32'(obs0), 32'd0);

        for (int t = 0; t < 40; t++) begin
            logic [5:0] op;
            logic [5:0] fn;
            op = ops[$urandom_range(7)];
            if (t % 8 == 7) op = 6'($urandom);
            fn = fns[$urandom_range(3)];
            if (fn == 6'd0) fn = 6'($urandom);
            run1($sformatf("rnd%0d", t), op, fn, 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
